// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      HALT     = 2'b10
   } state_t;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
   localparam int unsigned CNT_W_DEFAULT       = 16;

   // True when the ID instruction really depends on dst through src ($0 never counts).
   function automatic logic depMatch(input logic uses, input logic [4:0] src, input logic [4:0] dst);
      return uses && (src != 5'd0) && (src == dst);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; used for the stall/flush statistics.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall/flush control for the 5-stage MIPS pipeline,
// including variable-latency data-memory waits with a timeout into HALT.
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
   parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             ID_IsBranch,
   input  logic             BranchTaken,
   input  logic [4:0]       ID_EX_RegRd,
   input  logic             ID_EX_RegWrite,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       EX_MEM_RegRd,
   input  logic             EX_MEM_MemRead,
   input  logic             EX_MEM_MemWrite,
   input  logic             DMEM_Ready,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             ID_EX_Write,
   output logic             EX_MEM_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Bubble,
   output logic             MEM_WB_Bubble,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   state_t     r_state;
   state_t     w_nextState;
   logic [7:0] r_waitCnt;
   logic [7:0] w_nextWaitCnt;
   logic       r_memTimeout;
   logic       w_nextMemTimeout;

   logic w_matchEx;
   logic w_matchMem;
   logic w_memPending;
   logic w_freeze;
   logic w_loadUse;
   logic w_branchData;
   logic w_stall;
   logic w_flush;

   assign w_matchEx    = depMatch(ID_UsesRs, ID_Rs, ID_EX_RegRd)  || depMatch(ID_UsesRt, ID_Rt, ID_EX_RegRd);
   assign w_matchMem   = depMatch(ID_UsesRs, ID_Rs, EX_MEM_RegRd) || depMatch(ID_UsesRt, ID_Rt, EX_MEM_RegRd);
   assign w_memPending = (EX_MEM_MemRead || EX_MEM_MemWrite) && !DMEM_Ready;
   assign w_freeze     = (r_state == HALT) || w_memPending;
   assign w_loadUse    = ID_EX_MemRead && w_matchEx;
   assign w_branchData = ID_IsBranch && ((ID_EX_RegWrite && w_matchEx) || (EX_MEM_MemRead && w_matchMem));
   assign w_stall      = w_loadUse || w_branchData;
   // A stalled branch has invalid operands, so its taken result is ignored.
   assign w_flush      = ID_IsBranch && BranchTaken && !w_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= RUN;
         r_waitCnt    <= 8'd0;
         r_memTimeout <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_waitCnt    <= w_nextWaitCnt;
         r_memTimeout <= w_nextMemTimeout;
      end
   end

   always_comb begin
      w_nextState      = r_state;
      w_nextWaitCnt    = r_waitCnt;
      w_nextMemTimeout = r_memTimeout;
      case (r_state)
         RUN: begin
            if (w_memPending) begin
               w_nextState   = MEM_WAIT;
               w_nextWaitCnt = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (!w_memPending) begin
               w_nextState   = RUN;
               w_nextWaitCnt = 8'd0;
            end else if (r_waitCnt == 8'(MEM_TIMEOUT)) begin
               w_nextState      = HALT;
               w_nextMemTimeout = 1'b1;
            end else begin
               w_nextWaitCnt = r_waitCnt + 8'd1;
            end
         end
         HALT: begin
            w_nextState = HALT;
         end
         default: begin
            w_nextState   = RUN;
            w_nextWaitCnt = 8'd0;
         end
      endcase
   end

   // Priority: reset hold, then freeze, then load-use/branch-data stall, then flush.
   always_comb begin
      PCWrite       = 1'b1;
      IF_ID_Write   = 1'b1;
      ID_EX_Write   = 1'b1;
      EX_MEM_Write  = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Bubble  = 1'b0;
      MEM_WB_Bubble = 1'b0;
      if (!rst_n) begin
         PCWrite       = 1'b0;
         IF_ID_Write   = 1'b0;
         ID_EX_Write   = 1'b0;
         EX_MEM_Write  = 1'b0;
         ID_EX_Bubble  = 1'b1;
         MEM_WB_Bubble = 1'b1;
      end else if (w_freeze) begin
         PCWrite       = 1'b0;
         IF_ID_Write   = 1'b0;
         ID_EX_Write   = 1'b0;
         EX_MEM_Write  = 1'b0;
         MEM_WB_Bubble = 1'b1;
      end else if (w_stall) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end else if (w_flush) begin
         IF_ID_Flush = 1'b1;
      end
   end

   assign MemTimeout = r_memTimeout;

   sat_counter #(.W(CNT_W)) u_stallCounter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (!PCWrite),
      .clear (1'b0),
      .count (StallCount)
   );

   sat_counter #(.W(CNT_W)) u_flushCounter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (IF_ID_Flush),
      .clear (1'b0),
      .count (FlushCount)
   );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: a driver pushes model expectations,
// a monitor pops and compares them against the DUT each cycle.
module tb_hazard_stall_unit;

   localparam int TIMEOUT_P = 4;
   localparam int CNTW_P    = 4;
   localparam int CNT_MAX   = (1 << CNTW_P) - 1;

   typedef struct {
      logic       rstN;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       usesRs;
      logic       usesRt;
      logic       isBranch;
      logic       taken;
      logic [4:0] exRd;
      logic       exRegWrite;
      logic       exMemRead;
      logic [4:0] memRd;
      logic       memRead;
      logic       memWrite;
      logic       ready;
   } stim_t;

   typedef struct {
      int         cycle;
      logic [6:0] ctl;
      logic       memTo;
      int         stallC;
      int         flushC;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic [4:0]        ID_Rs, ID_Rt, ID_EX_RegRd, EX_MEM_RegRd;
   logic              ID_UsesRs, ID_UsesRt, ID_IsBranch, BranchTaken;
   logic              ID_EX_RegWrite, ID_EX_MemRead;
   logic              EX_MEM_MemRead, EX_MEM_MemWrite, DMEM_Ready;
   logic              PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
   logic              IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble, MemTimeout;
   logic [CNTW_P-1:0] StallCount, FlushCount;

   hazard_stall_unit #(.MEM_TIMEOUT(TIMEOUT_P), .CNT_W(CNTW_P)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ID_Rs           (ID_Rs),
      .ID_Rt           (ID_Rt),
      .ID_UsesRs       (ID_UsesRs),
      .ID_UsesRt       (ID_UsesRt),
      .ID_IsBranch     (ID_IsBranch),
      .BranchTaken     (BranchTaken),
      .ID_EX_RegRd     (ID_EX_RegRd),
      .ID_EX_RegWrite  (ID_EX_RegWrite),
      .ID_EX_MemRead   (ID_EX_MemRead),
      .EX_MEM_RegRd    (EX_MEM_RegRd),
      .EX_MEM_MemRead  (EX_MEM_MemRead),
      .EX_MEM_MemWrite (EX_MEM_MemWrite),
      .DMEM_Ready      (DMEM_Ready),
      .PCWrite         (PCWrite),
      .IF_ID_Write     (IF_ID_Write),
      .ID_EX_Write     (ID_EX_Write),
      .EX_MEM_Write    (EX_MEM_Write),
      .IF_ID_Flush     (IF_ID_Flush),
      .ID_EX_Bubble    (ID_EX_Bubble),
      .MEM_WB_Bubble   (MEM_WB_Bubble),
      .MemTimeout      (MemTimeout),
      .StallCount      (StallCount),
      .FlushCount      (FlushCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cycleNo = 0;

   // Reference model: consecutive frozen cycles of the current access, halt flag, event tallies.
   int   frozenRun = 0;
   bit   halted = 0;
   int   stallTally = 0;
   int   flushTally = 0;

   function automatic stim_t nopStim();
      stim_t s;
      s.rstN = 1'b1; s.rs = 5'd0; s.rt = 5'd0; s.usesRs = 1'b0; s.usesRt = 1'b0;
      s.isBranch = 1'b0; s.taken = 1'b0; s.exRd = 5'd0; s.exRegWrite = 1'b0;
      s.exMemRead = 1'b0; s.memRd = 5'd0; s.memRead = 1'b0; s.memWrite = 1'b0;
      s.ready = 1'b1;
      return s;
   endfunction

   function automatic bit readsReg(input stim_t s, input logic [4:0] r);
      return (r != 5'd0) && ((s.usesRs && s.rs == r) || (s.usesRt && s.rt == r));
   endfunction

   task automatic applyStimulus(input stim_t s);
      exp_t e;
      bit   freeze, stall, flush;
      @(negedge clk);
      rst_n = s.rstN; ID_Rs = s.rs; ID_Rt = s.rt; ID_UsesRs = s.usesRs; ID_UsesRt = s.usesRt;
      ID_IsBranch = s.isBranch; BranchTaken = s.taken; ID_EX_RegRd = s.exRd;
      ID_EX_RegWrite = s.exRegWrite; ID_EX_MemRead = s.exMemRead; EX_MEM_RegRd = s.memRd;
      EX_MEM_MemRead = s.memRead; EX_MEM_MemWrite = s.memWrite; DMEM_Ready = s.ready;
      cycleNo++;
      e.cycle = cycleNo;
      if (!s.rstN) begin
         frozenRun = 0; halted = 0; stallTally = 0; flushTally = 0;
         e.ctl = 7'b0000_011; e.memTo = 1'b0; e.stallC = 0; e.flushC = 0;
         expQ.push_back(e);
         return;
      end
      freeze = halted || ((s.memRead || s.memWrite) && !s.ready);
      stall  = (s.exMemRead && readsReg(s, s.exRd)) ||
               (s.isBranch && ((s.exRegWrite && readsReg(s, s.exRd)) ||
                               (s.memRead && readsReg(s, s.memRd))));
      flush  = s.isBranch && s.taken;
      if (freeze)     e.ctl = 7'b0000_001;
      else if (stall) e.ctl = 7'b0011_010;
      else if (flush) e.ctl = 7'b1111_100;
      else            e.ctl = 7'b1111_000;
      e.memTo  = halted;
      e.stallC = stallTally;
      e.flushC = flushTally;
      expQ.push_back(e);
      if (e.ctl[6] == 1'b0 && stallTally < CNT_MAX) stallTally++;
      if (e.ctl[2] == 1'b1 && flushTally < CNT_MAX) flushTally++;
      if (!halted) begin
         if (freeze) begin
            frozenRun++;
            if (frozenRun > TIMEOUT_P) halted = 1;
         end else begin
            frozenRun = 0;
         end
      end
   endtask

   task automatic checkOutput();
      exp_t       e;
      logic [6:0] act;
      e   = expQ.pop_front();
      act = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble};
      checks++;
      if (act !== e.ctl) begin
         errors++;
         $display("[TB] FAIL ctl cycle %0d: got %b expected %b", e.cycle, act, e.ctl);
      end
      checks++;
      if (MemTimeout !== e.memTo) begin
         errors++;
         $display("[TB] FAIL MemTimeout cycle %0d: got %b expected %b", e.cycle, MemTimeout, e.memTo);
      end
      checks++;
      if (StallCount !== CNTW_P'(e.stallC)) begin
         errors++;
         $display("[TB] FAIL StallCount cycle %0d: got %0d expected %0d", e.cycle, StallCount, e.stallC);
      end
      checks++;
      if (FlushCount !== CNTW_P'(e.flushC)) begin
         errors++;
         $display("[TB] FAIL FlushCount cycle %0d: got %0d expected %0d", e.cycle, FlushCount, e.flushC);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (expQ.size() > 0) checkOutput();
      end
   end

   initial begin
      stim_t s;
      rst_n = 1'b0; ID_Rs = '0; ID_Rt = '0; ID_UsesRs = 0; ID_UsesRt = 0; ID_IsBranch = 0;
      BranchTaken = 0; ID_EX_RegRd = '0; ID_EX_RegWrite = 0; ID_EX_MemRead = 0;
      EX_MEM_RegRd = '0; EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0; DMEM_Ready = 1;

      s = nopStim(); s.rstN = 1'b0;
      repeat (2) applyStimulus(s);
      applyStimulus(nopStim());

      // lw $8 in EX, add using $8 in ID
      s = nopStim(); s.exMemRead = 1; s.exRegWrite = 1; s.exRd = 5'd8; s.rs = 5'd8; s.usesRs = 1;
      applyStimulus(s);
      applyStimulus(nopStim());

      // same with register zero
      s = nopStim(); s.exMemRead = 1; s.exRegWrite = 1; s.exRd = 5'd0; s.rs = 5'd0; s.usesRs = 1;
      applyStimulus(s);

      // lw $9 followed by taken beq $9,$0
      s = nopStim(); s.exMemRead = 1; s.exRegWrite = 1; s.exRd = 5'd9;
      s.rs = 5'd9; s.usesRs = 1; s.usesRt = 1; s.isBranch = 1; s.taken = 1;
      applyStimulus(s);
      s.exMemRead = 0; s.exRegWrite = 0; s.exRd = 5'd0; s.memRead = 1; s.memRd = 5'd9;
      applyStimulus(s);
      s.memRead = 0; s.memRd = 5'd0;
      applyStimulus(s);
      applyStimulus(nopStim());

      // branch on an ALU result in EX
      s = nopStim(); s.exRegWrite = 1; s.exRd = 5'd5; s.rt = 5'd5; s.usesRt = 1; s.isBranch = 1;
      applyStimulus(s);

      // 3-cycle memory wait with a load-use pending behind it
      s = nopStim(); s.memRead = 1; s.ready = 0; s.exMemRead = 1; s.exRd = 5'd3; s.rs = 5'd3; s.usesRs = 1;
      repeat (3) applyStimulus(s);
      s.ready = 1;
      applyStimulus(s);
      applyStimulus(nopStim());

      // saturation of the stall counter
      s = nopStim(); s.exMemRead = 1; s.exRd = 5'd7; s.rt = 5'd7; s.usesRt = 1;
      repeat (20) applyStimulus(s);
      applyStimulus(nopStim());

      // timeout into HALT, then async reset out of it
      s = nopStim(); s.memWrite = 1; s.ready = 0;
      repeat (8) applyStimulus(s);
      repeat (3) applyStimulus(nopStim());
      s = nopStim(); s.rstN = 1'b0;
      applyStimulus(s);
      applyStimulus(nopStim());

      for (int i = 0; i < 600; i++) begin
         s = nopStim();
         s.rstN       = (i % 97 == 96) ? 1'b0 : 1'b1;
         s.rs         = 5'($urandom_range(0, 3));
         s.rt         = 5'($urandom_range(0, 3));
         s.usesRs     = 1'($urandom_range(0, 1));
         s.usesRt     = 1'($urandom_range(0, 1));
         s.isBranch   = ($urandom_range(0, 2) == 0);
         s.taken      = 1'($urandom_range(0, 1));
         s.exRd       = 5'($urandom_range(0, 3));
         s.exRegWrite = 1'($urandom_range(0, 1));
         s.exMemRead  = ($urandom_range(0, 2) == 0);
         s.memRd      = 5'($urandom_range(0, 3));
         s.memRead    = ($urandom_range(0, 2) == 0);
         s.memWrite   = ($urandom_range(0, 3) == 0);
         s.ready      = ($urandom_range(0, 2) != 0);
         applyStimulus(s);
      end

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
      #5;
      if (expQ.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
